// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encoding, requester ids and sizing helper for the memory bus arbiter
//
// Purpose: one-hot arbiter states, requester ids and the timeout counter
// width rule shared by mem_bus_arbiter and bus_timeout_cnt.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'b001,
    ARB_ACCESS   = 3'b010,
    ARB_COMPLETE = 3'b100
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // Counter must hold 0..TIMEOUT; a disabled timeout still gets one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - saturating wait-cycle counter that flags an ACCESS timeout
//
// Purpose: counts ACCESS cycles without an acknowledge and reports when the
// count is about to reach TIMEOUT (TIMEOUT = 0 disables the timeout).
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-low reset
//   clr     in  clear the count (COMPLETE state)
//   en      in  count this cycle (ACCESS without mem_ack)
//   expired out this cycle's increment reaches TIMEOUT
module bus_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT; with TIMEOUT = 0 the count never leaves zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Raised on the cycle whose increment lands on TIMEOUT so the arbiter
  // leaves ACCESS after exactly TIMEOUT unacknowledged cycles.
  assign expired = (TIMEOUT != 0) && en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
//
// Purpose: grants fetch or data access to the memory port, sequences the
// IDLE -> ACCESS -> COMPLETE handshake, returns per-requester done pulses
// and a timeout error pulse. All outputs are registered.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   f_req, f_addr, f_done         fetch requester (read only)
//   d_req, d_we, d_addr, d_wdata  data requester (load/store)
//   d_done                        data transaction finished
//   rdata                         read data of the last completed read
//   bus_err                       pulses with *_done on a timeout
//   busy                          high outside IDLE
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory port
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              f_done_q, f_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_err_q, bus_err_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_clr, cnt_en, cnt_expired;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    f_done_d     = 1'b0;
    d_done_d     = 1'b0;
    bus_err_d    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (f_req || d_req) begin
          // On a tie the requester that did not go last wins.
          grant_d = (f_req && d_req) ? ~last_grant_q : (d_req ? REQ_DATA : REQ_FETCH);
          if (grant_d == REQ_DATA) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = f_addr;
            mem_we_d    = 1'b0;
          end
          mem_en_d = 1'b1;
          state_d  = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          f_done_d = (grant_q == REQ_FETCH);
          d_done_d = (grant_q == REQ_DATA);
          state_d  = ARB_COMPLETE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            // The registered bus_err doubles as the error flag for COMPLETE.
            mem_en_d  = 1'b0;
            mem_we_d  = 1'b0;
            bus_err_d = 1'b1;
            f_done_d  = (grant_q == REQ_FETCH);
            d_done_d  = (grant_q == REQ_DATA);
            state_d   = ARB_COMPLETE;
          end
        end
      end

      ARB_COMPLETE: begin
        last_grant_d = grant_q;
        cnt_clr      = 1'b1;
        state_d      = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= REQ_FETCH;
      last_grant_q <= REQ_DATA;
      f_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      f_done_q     <= f_done_d;
      d_done_q     <= d_done_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [7:0]  f_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0, mem_rdata = '0;
  logic        f_done, d_done, bus_err, busy, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, rdata;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .bus_err(bus_err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction is described by the edge it was
  // granted on and the edge it ended on (ack or timeout); outputs follow
  // from those timestamps.
  int          edge_n = 0;
  bit          in_txn = 0;
  int          t_grant = 0, t_end = -1;
  bit          who = 0, m_we = 0, m_err = 0, m_last = 1;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_wdata = '0, m_rdata = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_txn = 0; t_end = -1; m_last = 1; m_rdata = '0; m_err = 0; edge_n = 0;
    end else begin
      edge_n++;
      if (in_txn && t_end >= 0) begin
        in_txn = 0;
        m_last = who;
      end else if (in_txn) begin
        if (mem_ack) begin
          t_end = edge_n; m_err = 0;
          if (!m_we) m_rdata = mem_rdata;
        end else if (TMO != 0 && edge_n - t_grant == TMO) begin
          t_end = edge_n; m_err = 1;
        end
      end else if (f_req || d_req) begin
        who = (f_req && d_req) ? !m_last : d_req;
        if (who) begin m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; end
        else begin m_addr = f_addr; m_we = 0; end
        in_txn = 1; t_grant = edge_n; t_end = -1;
      end
    end
  end

  bit e_busy = 0, e_en = 0, e_fd = 0, e_dd = 0, e_who = 0;

  always @(negedge clk) begin
    e_busy = in_txn;
    e_en   = in_txn && (t_end < 0);
    e_fd   = in_txn && (t_end >= 0) && !who;
    e_dd   = in_txn && (t_end >= 0) && who;
    e_who  = who;
    chk("busy", busy, e_busy);
    chk("mem_en", mem_en, e_en);
    chk("f_done", f_done, e_fd);
    chk("d_done", d_done, e_dd);
    chk("bus_err", bus_err, (e_fd || e_dd) && m_err);
    chk("rdata", rdata, m_rdata);
    if (e_en) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Random requesters and memory: a requester raises req when idle, drops it
  // on the edge it sees its done, and may drop it early once granted.
  bit rand_on = 0;
  bit f_out = 0, d_out = 0;
  int ack_pct = 50;

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      if (f_out && e_fd) begin
        f_out = 0; f_req = 0;
      end else if (!f_out) begin
        if ($urandom_range(0, 99) < 30) begin f_out = 1; f_req = 1; f_addr = 8'($urandom); end
      end else if (f_req && e_en && !e_who && $urandom_range(0, 99) < 15) begin
        f_req = 0;
      end
      if (d_out && e_dd) begin
        d_out = 0; d_req = 0;
      end else if (!d_out) begin
        if ($urandom_range(0, 99) < 30) begin
          d_out = 1; d_req = 1; d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = 16'($urandom);
        end
      end else if (d_req && e_en && e_who && $urandom_range(0, 99) < 15) begin
        d_req = 0;
      end
      mem_ack   = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = 16'($urandom);
    end
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    int en_cnt, pulses;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_mem_en", mem_en, 0); chk("rst_rdata", rdata, 0);
    chk("rst_done", {f_done, d_done, bus_err}, 0); chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests after reset: fetch first, data three cycles later
    drive_edge();
    f_req = 1; f_addr = 8'h44; d_req = 1; d_addr = 8'h33; d_we = 0; mem_ack = 1; mem_rdata = 16'h5555;
    @(negedge clk);
    @(negedge clk); chk("t2_fetch_addr", mem_addr, 8'h44); chk("t2_fetch_we", mem_we, 0);
    @(negedge clk); chk("t2_f_done", f_done, 1); chk("t2_no_d_done", d_done, 0);
    drive_edge(); f_req = 0;
    @(negedge clk); chk("t2_idle_gap", busy, 0);
    @(negedge clk); chk("t2_data_addr", mem_addr, 8'h33);
    @(negedge clk); chk("t2_d_done", d_done, 1); chk("t2_rdata", rdata, 16'h5555);
    drive_edge(); d_req = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    // Single fetch with immediate ack
    drive_edge();
    f_req = 1; f_addr = 8'h10; mem_ack = 1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    @(negedge clk); chk("t1_mem_en", mem_en, 1); chk("t1_mem_we", mem_we, 0); chk("t1_addr", mem_addr, 8'h10);
    @(negedge clk); chk("t1_f_done", f_done, 1); chk("t1_rdata", rdata, 16'hBEEF); chk("t1_en_low", mem_en, 0);
    drive_edge(); f_req = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    // Store with four wait cycles
    drive_edge();
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 16'h1234; mem_ack = 0; mem_rdata = 16'hDEAD;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      if (i == 4) mem_ack = 1;
      @(negedge clk);
      chk("t3_store_held", {mem_en, mem_we, mem_wdata}, {2'b11, 16'h1234});
    end
    @(negedge clk); chk("t3_d_done", d_done, 1); chk("t3_rdata_kept", rdata, 16'hBEEF);
    drive_edge(); d_req = 0; d_we = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    // Load that never gets an ack
    drive_edge();
    d_req = 1; d_we = 0; d_addr = 8'h77;
    en_cnt = 0; seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (d_done) begin
        seen = 1;
        chk("t4_bus_err", bus_err, 1);
      end else if (mem_en) begin
        en_cnt++;
      end
    end
    chk("t4_done_seen", seen, 1); chk("t4_access_cycles", en_cnt, TMO); chk("t4_rdata_kept", rdata, 16'hBEEF);
    drive_edge(); d_req = 0;
    repeat (2) @(negedge clk);

    // Stray ack in IDLE, then a fetch whose req drops during ACCESS
    drive_edge(); mem_ack = 1;
    @(negedge clk); chk("t6_stray_busy", busy, 0);
    @(negedge clk); chk("t6_stray_done", f_done, 0);
    drive_edge(); mem_ack = 0; f_req = 1; f_addr = 8'h5A; mem_rdata = 16'h0F0F;
    @(negedge clk);
    drive_edge(); f_req = 0; mem_ack = 1;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (f_done) pulses++;
    end
    chk("t6_one_done", pulses, 1); chk("t6_rdata", rdata, 16'h0F0F);
    drive_edge(); mem_ack = 0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of ACCESS
    drive_edge(); f_req = 1; f_addr = 8'hC3; mem_ack = 0;
    @(negedge clk);
    @(negedge clk); chk("t5_pre_en", mem_en, 1); chk("t5_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1 chk("t5_async_en", mem_en, 0); chk("t5_async_busy", busy, 0);
    chk("t5_async_rdata", rdata, 0); chk("t5_async_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    mem_ack = 1; mem_rdata = 16'hA5A5;
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (f_done) seen = 1;
    end
    chk("t5_after_done", seen, 1); chk("t5_after_rdata", rdata, 16'hA5A5);
    drive_edge(); f_req = 0; mem_ack = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic: normal, timeout-heavy, then always-ack
    ack_pct = 50; rand_on = 1;
    repeat (1500) @(negedge clk);
    ack_pct = 3;
    repeat (1000) @(negedge clk);
    ack_pct = 100;
    repeat (500) @(negedge clk);
    rand_on = 0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
